// File: rtl/axi_stream_frame_sender.sv
// AXI-Stream frame source: streams a host-loaded image as a zero-padded,
// column-major frame, PIX_PER_WORD pixels per word, with valid/ready flow control.
module axi_stream_frame_sender #(
    parameter int IMAGE_HEIGHT = 200,
    parameter int IMAGE_WIDTH  = 200,
    parameter int NB_PIXEL     = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int PIX_PER_WORD = DATA_WIDTH / NB_PIXEL,
    parameter int RAW_H        = IMAGE_HEIGHT - 2,
    parameter int RAW_W        = IMAGE_WIDTH - 2,
    parameter int NB_ADDR      = $clog2(RAW_H * RAW_W)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [NB_ADDR-1:0]    i_wr_addr,
    input  logic [NB_PIXEL-1:0]   i_wr_data,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready
);

    localparam int ROW_W     = $clog2(IMAGE_HEIGHT);
    localparam int COL_W     = $clog2(IMAGE_WIDTH);
    localparam int LANE_W    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int MEM_DEPTH = RAW_H * RAW_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [NB_PIXEL-1:0]   r_mem [MEM_DEPTH];
    logic [NB_PIXEL-1:0]   r_rd_data;
    logic                  r_pad_d;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic [LANE_W-1:0]     r_lane;
    logic                  r_is_last;
    logic [DATA_WIDTH-1:0] r_asm;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_finish;
    logic                  w_resume;
    logic                  w_handshake;
    logic                  w_fetch_done;
    logic                  w_pad;
    logic                  w_rd_en;
    logic                  w_wr_in_range;
    logic [NB_ADDR-1:0]    w_addr;
    logic [LANE_W-1:0]     w_cap_lane;
    logic [NB_PIXEL-1:0]   w_lane_val;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_handshake   = m_axis_valid & m_axis_ready;
    assign w_fetch_done  = (r_lane == LANE_W'(PIX_PER_WORD - 1));
    assign w_pad         = (r_row == '0) || (r_row == ROW_W'(IMAGE_HEIGHT - 1)) ||
                           (r_col == '0) || (r_col == COL_W'(IMAGE_WIDTH - 1));
    assign w_rd_en       = (r_state == S_FETCH) && !w_pad;
    assign w_wr_in_range = (32'(i_wr_addr) < 32'(MEM_DEPTH));
    // Padded (row, col) maps onto the raw image one row and one column up-left.
    assign w_addr        = NB_ADDR'(r_row - ROW_W'(1)) * NB_ADDR'(RAW_W) +
                           NB_ADDR'(r_col - COL_W'(1));
    assign w_cap_lane    = r_lane - LANE_W'(1);
    assign w_lane_val    = r_pad_d ? '0 : r_rd_data;

    always_comb begin
        w_word = r_asm;
        w_word[(PIX_PER_WORD-1)*NB_PIXEL +: NB_PIXEL] = w_lane_val;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        w_resume     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_FETCH;
                    w_accept     = 1'b1;
                end
            end
            S_FETCH: begin
                if (w_fetch_done) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next_state = S_HOLD;
                w_load       = 1'b1;
            end
            S_HOLD: begin
                if (w_handshake) begin
                    if (m_axis_last) begin
                        w_next_state = S_IDLE;
                        w_finish     = 1'b1;
                    end else begin
                        w_next_state = S_FETCH;
                        w_resume     = 1'b1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Frame memory has no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !o_busy && w_wr_in_range) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_lane       <= '0;
            r_pad_d      <= 1'b0;
            r_is_last    <= 1'b0;
            r_asm        <= '0;
        end else begin
            o_done <= w_finish;
            if (w_accept) begin
                o_busy    <= 1'b1;
                r_row     <= '0;
                r_col     <= '0;
                r_lane    <= '0;
                r_is_last <= 1'b0;
            end
            if (r_state == S_FETCH) begin
                r_pad_d <= w_pad;
                r_lane  <= w_fetch_done ? '0 : r_lane + LANE_W'(1);
                if (r_lane != '0) begin
                    r_asm[w_cap_lane*NB_PIXEL +: NB_PIXEL] <= w_lane_val;
                end
                if (r_row == ROW_W'(IMAGE_HEIGHT - 1)) begin
                    r_row <= '0;
                    if (r_col == COL_W'(IMAGE_WIDTH - 1)) begin
                        r_col     <= '0;
                        r_is_last <= 1'b1;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end
            if (w_load) begin
                m_axis_data  <= w_word;
                m_axis_last  <= r_is_last;
                m_axis_valid <= 1'b1;
            end
            if (w_resume) begin
                m_axis_valid <= 1'b0;
            end
            if (w_finish) begin
                m_axis_valid <= 1'b0;
                m_axis_last  <= 1'b0;
                o_busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_frame_sender.sv
// Scoreboard bench for axi_stream_frame_sender on a small 8x6 padded frame;
// expected words come from a pixel-level model of the padded image.
module tb_axi_stream_frame_sender;

    localparam int H       = 8;
    localparam int W       = 6;
    localparam int NBP     = 8;
    localparam int DW      = 32;
    localparam int PPW     = DW / NBP;
    localparam int RAW_H   = H - 2;
    localparam int RAW_W   = W - 2;
    localparam int NB_ADDR = $clog2(RAW_H * RAW_W);
    localparam int WPC     = H / PPW;
    localparam int WPF     = W * WPC;

    logic               clk = 1'b0;
    logic               rst;
    logic               wrEn;
    logic [NB_ADDR-1:0] wrAddr;
    logic [NBP-1:0]     wrData;
    logic               start;
    logic               busy;
    logic               done;
    logic               valid;
    logic [DW-1:0]      data;
    logic               last;
    logic               ready;

    axi_stream_frame_sender #(
        .IMAGE_HEIGHT(H),
        .IMAGE_WIDTH (W),
        .NB_PIXEL    (NBP),
        .DATA_WIDTH  (DW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wr_en     (wrEn),
        .i_wr_addr   (wrAddr),
        .i_wr_data   (wrData),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .m_axis_valid(valid),
        .m_axis_data (data),
        .m_axis_last (last),
        .m_axis_ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  memModel [RAW_H*RAW_W];
    logic [32:0] expQ [$];
    logic [32:0] expWord;
    logic [31:0] rxWords [WPF];
    int          frameRx = 0;
    int          startCyc = 0;
    int          firstValidCyc = -1;
    int          prevHsCyc = -1;
    int          lastHsCyc = -100;
    int          doneCount = 0;
    bit          spacingOn = 1'b0;
    int          readyMode = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pixel(input int row, input int col);
        if (row == 0 || row == H-1 || col == 0 || col == W-1) return 8'h00;
        return memModel[(row-1)*RAW_W + (col-1)];
    endfunction

    function automatic logic [31:0] wordOf(input int w);
        logic [31:0] word;
        int col;
        int rowBase;
        col     = w / WPC;
        rowBase = (w % WPC) * PPW;
        word    = '0;
        for (int k = 0; k < PPW; k++) word[k*NBP +: NBP] = pixel(rowBase + k, col);
        return word;
    endfunction

    // Ready pattern: 0 = always high, 1 = random, otherwise held low.
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever a handshake is about to occur.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (valid && ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%08h, expected no word", data);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput($sformatf("word%0d_data", frameRx), data, expWord[31:0]);
                    checkOutput($sformatf("word%0d_last", frameRx), 32'(last), 32'(expWord[32]));
                    if (spacingOn && prevHsCyc >= 0)
                        checkOutput("handshake_spacing", 32'(cyc - prevHsCyc), 32'(PPW + 2));
                    prevHsCyc = cyc;
                    if (last) lastHsCyc = cyc;
                    if (frameRx < WPF) rxWords[frameRx] = data;
                    frameRx++;
                end
            end
            if (done) begin
                doneCount++;
                checkOutput("done_timing", 32'(cyc), 32'(lastHsCyc + 1));
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic writePixel(input int addr, input logic [7:0] value, input bit accepted);
        @(posedge clk);
        #1;
        wrEn   = 1'b1;
        wrAddr = NB_ADDR'(addr);
        wrData = value;
        if (accepted) memModel[addr] = value;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Starts a frame and queues every word the model predicts for it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int w = 0; w < WPF; w++) expQ.push_back({(w == WPF-1), wordOf(w)});
        frameRx       = 0;
        firstValidCyc = -1;
        prevHsCyc     = -1;
        startCyc      = cyc;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = doneCount;
        while (doneCount == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput({name, "_done_count"}, 32'(doneCount - d0), 32'd1);
        checkOutput({name, "_queue_left"}, 32'(expQ.size()), 32'd0);
    endtask

    task automatic waitRx(input int target, input int budget);
        int n;
        n = 0;
        while (frameRx < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frameRx < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_words: got %0d words, expected %0d", frameRx, target);
        end
    endtask

    task automatic waitValid(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_valid: got valid=0, expected valid=1");
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        rst    = 1'b1;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_data", data, 32'd0);
        checkOutput("reset_last", 32'(last), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int a = 0; a < RAW_H*RAW_W; a++) writePixel(a, 8'(a + 1), 1'b1);

        $display("[TB] frame 1: ordering and latency");
        spacingOn = 1'b1;
        readyMode = 0;
        applyStimulus();
        waitDone("frame1", 400);
        checkOutput("first_valid_latency", 32'(firstValidCyc - startCyc), 32'd6);
        checkOutput("word0_const", rxWords[0], 32'h0000_0000);
        checkOutput("word1_const", rxWords[1], 32'h0000_0000);
        checkOutput("word2_const", rxWords[2], 32'h0905_0100);
        checkOutput("word3_const", rxWords[3], 32'h0015_110D);
        checkOutput("word10_const", rxWords[10], 32'h0000_0000);
        checkOutput("word11_const", rxWords[11], 32'h0000_0000);
        spacingOn = 1'b0;

        $display("[TB] frame 2: back-pressure and busy guards");
        applyStimulus();
        waitRx(2, 200);
        readyMode = 2;
        waitValid(50);
        writePixel(0, 8'hFF, 1'b0);
        pulseStart();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(valid), 32'd1);
            checkOutput("hold_data", data, 32'h0905_0100);
        end
        readyMode = 0;
        waitDone("frame2", 400);

        $display("[TB] frame 3: memory untouched by busy write");
        applyStimulus();
        waitDone("frame3", 400);
        checkOutput("guard_lane1", 32'(rxWords[2][15:8]), 32'h01);

        $display("[TB] frame 4: reset mid-frame");
        applyStimulus();
        waitRx(5, 200);
        waitValid(50);
        d0 = doneCount;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_valid", 32'(valid), 32'd0);
        checkOutput("midreset_last", 32'(last), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midreset_no_done", 32'(doneCount - d0), 32'd0);

        $display("[TB] frame 5: replay after reset");
        applyStimulus();
        waitDone("frame5", 400);
        checkOutput("replay_word2", rxWords[2], 32'h0905_0100);

        $display("[TB] frames 6-8: random contents and random ready");
        for (int it = 0; it < 3; it++) begin
            readyMode = 0;
            for (int a = 0; a < RAW_H*RAW_W; a++) writePixel(a, 8'($urandom), 1'b1);
            readyMode = 1;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            applyStimulus();
            waitDone("random_frame", 2000);
        end
        readyMode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
